// File: rtl/quadrature_step_generator.sv
// Quadrature step generator: turns step commands into a Gray-coded A/B waveform
// matching a mechanical rotary encoder, and tracks a wrapping detent position.
module quadrature_step_generator #(
  parameter int unsigned PHASE_CYCLES = 4,
  parameter int unsigned STEP_W       = 8,
  parameter int unsigned POS_W        = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  output logic              output_A,
  output logic              output_B,
  output logic              busy,
  output logic              done,
  output logic [POS_W-1:0]  position
);

  localparam int unsigned TMR_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(PHASE_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, P1, P2, P3, P4} state_t;

  state_t            state;
  logic [TMR_W-1:0]  timer;
  logic [STEP_W-1:0] remaining;
  logic              dir_q;
  logic              abort_pend;
  logic              accept;
  logic              phase_end;

  assign cmd_ready = (state == IDLE) && !reset && !abort;
  assign accept    = cmd_valid && cmd_ready;
  assign phase_end = (timer == TMR_LAST);

  // A/B codes are registered alongside the state so the pins never see a comb path.
  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      timer      <= '0;
      remaining  <= '0;
      dir_q      <= 1'b0;
      abort_pend <= 1'b0;
      output_A   <= 1'b0;
      output_B   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      position   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            dir_q     <= cmd_dir;
            remaining <= cmd_steps;
            timer     <= '0;
            if (cmd_steps != '0) begin
              state              <= P1;
              busy               <= 1'b1;
              {output_A, output_B} <= cmd_dir ? 2'b01 : 2'b10;
            end else begin
              done <= 1'b1;
            end
          end
        end
        default: begin
          if (abort) abort_pend <= 1'b1;
          if (!phase_end) begin
            timer <= timer + TMR_W'(1);
          end else begin
            timer <= '0;
            case (state)
              P1: begin
                state                <= P2;
                {output_A, output_B} <= 2'b11;
                position             <= dir_q ? position + POS_W'(1) : position - POS_W'(1);
              end
              P2: begin
                state                <= P3;
                {output_A, output_B} <= dir_q ? 2'b10 : 2'b01;
              end
              P3: begin
                state                <= P4;
                {output_A, output_B} <= 2'b00;
              end
              default: begin
                // End of detent: chain straight into the next step unless told to stop.
                remaining <= remaining - STEP_W'(1);
                if ((remaining > STEP_W'(1)) && !abort_pend && !abort) begin
                  state                <= P1;
                  {output_A, output_B} <= dir_q ? 2'b01 : 2'b10;
                end else begin
                  state      <= IDLE;
                  busy       <= 1'b0;
                  done       <= 1'b1;
                  abort_pend <= 1'b0;
                end
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_quadrature_step_generator.sv
// Scoreboard bench for quadrature_step_generator: stimulus queues expected A/B
// transitions and done pulses; a negedge monitor pops and compares them.
module tb_quadrature_step_generator;
  localparam int unsigned PC     = 4;
  localparam int unsigned STEP_W = 8;
  localparam int unsigned POS_W  = 8;

  logic              clock;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_dir;
  logic [STEP_W-1:0] cmd_steps;
  logic              abort;
  logic              output_A;
  logic              output_B;
  logic              busy;
  logic              done;
  logic [POS_W-1:0]  position;

  quadrature_step_generator #(.PHASE_CYCLES(PC), .STEP_W(STEP_W), .POS_W(POS_W)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_dir(cmd_dir), .cmd_steps(cmd_steps), .abort(abort),
    .output_A(output_A), .output_B(output_B), .busy(busy), .done(done), .position(position)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int               kind;  // 0 = A/B change, 1 = done pulse
    logic [1:0]       ab;
    int               rel;
    logic [POS_W-1:0] pos;
  } ev_t;

  ev_t        exp_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         accept_cyc = 0;
  int         done_cnt = 0;
  logic [1:0] prev_ab = 2'b00;
  logic [1:0] mon_ab;
  ev_t        mon_e;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push_ab(input logic [1:0] ab, input int rel);
    ev_t e;
    e.kind = 0; e.ab = ab; e.rel = rel; e.pos = '0;
    exp_q.push_back(e);
  endtask

  task automatic push_done(input int rel, input logic [POS_W-1:0] pos);
    ev_t e;
    e.kind = 1; e.ab = 2'b00; e.rel = rel; e.pos = pos;
    exp_q.push_back(e);
  endtask

  // One detent: CW 01,11,10,00 and CCW 10,11,01,00, each held PC clocks.
  task automatic push_step(input logic dir, input int base);
    push_ab(dir ? 2'b01 : 2'b10, base);
    push_ab(2'b11, base + PC);
    push_ab(dir ? 2'b10 : 2'b01, base + 2 * PC);
    push_ab(2'b00, base + 3 * PC);
  endtask

  always @(negedge clock) begin
    mon_ab = {output_A, output_B};
    if (mon_ab != prev_ab) begin
      if (!reset) check("gray_one_bit", $countones(mon_ab ^ prev_ab), 1);
      check("ab_event_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("ab_event_kind", mon_e.kind, 0);
        check("ab_code", mon_ab, mon_e.ab);
        check("ab_cycle", cyc - accept_cyc, mon_e.rel);
      end
    end
    prev_ab = mon_ab;
    if (done) begin
      done_cnt++;
      check("done_expected", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        check("done_event_kind", mon_e.kind, 1);
        check("done_cycle", cyc - accept_cyc, mon_e.rel);
        check("done_position", position, mon_e.pos);
      end
      check("done_busy_low", busy, 0);
      if (!abort) check("done_cmd_ready", cmd_ready, 1);
    end
  end

  task automatic issue(input logic dir, input int steps);
    @(negedge clock); #1;
    check("cmd_ready_before_accept", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_dir   = dir;
    cmd_steps = STEP_W'(steps);
    @(posedge clock); #1;
    accept_cyc = cyc;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start;
    bit seen;
    start = done_cnt;
    seen  = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clock); #1;
      if (done_cnt != start) seen = 1'b1;
    end
    check("done_within_budget", seen, 1);
  endtask

  task automatic wait_rel(input int r);
    for (int i = 0; i < 200 && (cyc - accept_cyc) < r; i++) begin
      @(negedge clock); #1;
    end
    check("reached_rel_cycle", cyc - accept_cyc, r);
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock); #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0; abort = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock); #1;
    check("reset_ab", {output_A, output_B}, 0);
    check("reset_position", position, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_cmd_ready_masked", cmd_ready, 0);
    reset = 1'b0;
    #1 check("idle_cmd_ready", cmd_ready, 1);

    // Three CW detents.
    push_step(1'b1, 0); push_step(1'b1, 16); push_step(1'b1, 32); push_done(48, 8'd3);
    issue(1'b1, 3);
    check("busy_after_accept", busy, 1);
    wait_done(70);
    check("pos_after_cw3", position, 3);

    // One CCW detent from zero wraps to 255.
    do_reset();
    check("pos_cleared", position, 0);
    push_step(1'b0, 0); push_done(16, 8'd255);
    issue(1'b0, 1);
    wait_done(30);
    check("pos_ccw_wrap", position, 255);

    // Zero-step command: done next cycle, no motion, busy never rises.
    push_done(0, 8'd255);
    issue(1'b1, 0);
    check("zero_step_busy", busy, 0);
    wait_done(5);
    @(negedge clock); #1;
    check("zero_step_done_single", done, 0);
    check("zero_step_busy_after", busy, 0);
    check("zero_step_ab", {output_A, output_B}, 0);

    // CW from 255 wraps to 0.
    push_step(1'b1, 0); push_done(16, 8'd0);
    issue(1'b1, 1);
    wait_done(30);
    check("pos_cw_wrap", position, 0);

    // Abort while idle only masks cmd_ready.
    @(negedge clock); #1;
    abort = 1'b1;
    #1 check("abort_idle_masks_ready", cmd_ready, 0);
    abort = 1'b0;
    #1 check("abort_idle_release", cmd_ready, 1);
    check("abort_idle_busy", busy, 0);

    // Ten-step command aborted in step 2 P3; a command offered while busy is ignored.
    do_reset();
    push_step(1'b1, 0); push_step(1'b1, 16); push_done(32, 8'd2);
    issue(1'b1, 10);
    wait_rel(3);
    cmd_valid = 1'b1; cmd_dir = 1'b0; cmd_steps = STEP_W'(1);
    wait_rel(5);
    check("busy_cmd_ready_low", cmd_ready, 0);
    cmd_valid = 1'b0;
    wait_rel(25);
    abort = 1'b1;
    wait_rel(26);
    abort = 1'b0;
    wait_done(60);
    check("pos_after_abort", position, 2);

    // Reset during P2 forces 00 and clears position on that edge.
    do_reset();
    push_ab(2'b01, 0); push_ab(2'b11, 4); push_ab(2'b00, 6);
    issue(1'b1, 2);
    wait_rel(5);
    check("pos_in_p2", position, 1);
    reset = 1'b1;
    @(negedge clock); #1;
    check("midreset_ab", {output_A, output_B}, 0);
    check("midreset_position", position, 0);
    check("midreset_busy", busy, 0);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    #1;
    check("no_stray_after_reset_pos", position, 0);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
